// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the boot loader.
// The slave side is the loader. The master side is the producer/test harness.
interface imem_loader_if;
  logic        start;
  logic [15:0] word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        cpu_stall;
  logic        done;
  logic        err_overflow;

  modport slave (
    input  start, word_count, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_stall, done, err_overflow
  );

  modport master (
    output start, word_count, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_stall, done, err_overflow
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer. It packs a byte stream big-endian into 32-bit
// words and writes them to consecutive word addresses. The CPU stays stalled during the load.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'd0,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input logic         clk,
  input logic         rst_n,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

  state_t      state;
  logic [31:0] addr;
  logic [15:0] remaining;
  logic [1:0]  idx;
  logic [23:0] pack;

  assign bus.cpu_stall = bus.busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      addr             <= BASE_ADDR;
      remaining        <= '0;
      idx              <= '0;
      pack             <= '0;
      bus.byte_ready   <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= BASE_ADDR;
      bus.mem_wdata    <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.err_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.word_count == 16'd0) begin
              bus.done <= 1'b1;
              state    <= FINISH;
            end else if (32'(bus.word_count) > DEPTH_WORDS) begin
              bus.err_overflow <= 1'b1;
              bus.done         <= 1'b1;
              state            <= FINISH;
            end else begin
              remaining        <= bus.word_count;
              addr             <= BASE_ADDR;
              idx              <= '0;
              bus.err_overflow <= 1'b0;
              bus.busy         <= 1'b1;
              bus.byte_ready   <= 1'b1;
              state            <= COLLECT;
            end
          end
        end

        COLLECT: begin
          if (bus.byte_valid && bus.byte_ready) begin
            // pack holds the three earlier bytes. The fourth byte completes the word directly.
            pack <= {pack[15:0], bus.byte_in};
            idx  <= idx + 2'd1;
            if (idx == 2'd3) begin
              bus.mem_we     <= 1'b1;
              bus.mem_addr   <= addr;
              bus.mem_wdata  <= {pack, bus.byte_in};
              bus.byte_ready <= 1'b0;
              state          <= WRITE;
            end
          end
        end

        WRITE: begin
          bus.mem_we <= 1'b0;
          addr       <= addr + 32'd4;
          remaining  <= remaining - 16'd1;
          idx        <= '0;
          if (remaining == 16'd1) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= FINISH;
          end else begin
            bus.byte_ready <= 1'b1;
            state          <= COLLECT;
          end
        end

        FINISH: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the pipelined MIPS instruction memory. It accepts a byte stream over a valid/ready handshake, packs four bytes big-endian into one 32-bit instruction, and writes each word to consecutive word-aligned byte addresses (0, 4, 8, …). While loading, it holds the CPU fetch stage in stall. It is the write-side counterpart to the fetch path that reads instruction memory by byte address.

## Interface
Parameters:
- BASE_ADDR, 32'd0, byte address of the first instruction written
- DEPTH_WORDS, 256, instruction memory capacity in 32-bit words

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle load request; sampled only in IDLE
- word_count  input  16  number of words to load; sampled with start
- byte_in  input  8  stream byte
- byte_valid  input  1  byte_in valid
- byte_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  instruction memory write enable
- mem_addr  output  32  byte address, always word-aligned
- mem_wdata  output  32  packed instruction
- busy  output  1  load in progress
- cpu_stall  output  1  equals busy
- done  output  1  one-cycle pulse at end of load
- err_overflow  output  1  sticky; word_count exceeded DEPTH_WORDS

## Operation
- FSM states: IDLE, COLLECT, WRITE, FINISH.
- IDLE:
  - If start=1 and word_count=0: go to FINISH; no writes.
  - If start=1 and word_count>DEPTH_WORDS: set err_overflow, go to FINISH; no writes.
  - Otherwise, on start: latch the remaining count = word_count, set addr = BASE_ADDR, clear the byte index, clear err_overflow, go to COLLECT.
  - start=0: stay in IDLE.
- COLLECT:
  - byte_ready=1.
  - On byte_valid&&byte_ready, shift the byte into the packing register. Byte index 0 goes to [31:24], 1 to [23:16], 2 to [15:8], 3 to [7:0].
  - Acceptance of the 4th byte moves to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=addr, mem_wdata=packed word, byte_ready=0.
  - On exit: addr+=4, remaining count−=1, byte index=0.
  - Go to FINISH if the remaining count is now 0, else COLLECT.
- FINISH (one cycle): done=1, go to IDLE.
- busy=1 in COLLECT and WRITE only.
- start outside IDLE is ignored.
- Address arithmetic is 32-bit. It cannot wrap because word_count≤DEPTH_WORDS is enforced.
- Reset mid-load:
  - All state clears immediately.
  - The partial word is discarded and never written.
  - Words already written remain in memory.

## Timing
- Reset values: byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, cpu_stall=0, done=0, err_overflow=0. FSM=IDLE.
- start accepted at edge T: busy=1 and byte_ready=1 from cycle T+1.
- 4th byte of a word accepted at edge N:
  - mem_we=1 during cycle N+1, with the write occurring at edge N+1.
  - byte_ready=0 during cycle N+1.
  - byte_ready returns to 1 in cycle N+2.
- Maximum throughput: one word per 5 cycles.
- byte_valid with byte_ready=0 is held off. The producer must hold byte_in and byte_valid until accepted.
- Last write at edge N+1: done=1 and busy=0 in cycle N+2. FINISH then returns to IDLE.
- Rejected start (count 0 or overflow) at edge T: done=1 in cycle T+1. err_overflow asserts in cycle T+1, if applicable.
- mem_addr and mem_wdata are registered outputs, stable for the whole WRITE cycle.

## Test plan
- Reset, then start with word_count=2 and bytes 8C,01,00,04,AC,02,00,08 with byte_valid held high:
  - mem_we pulses twice.
  - Writes are addr 0 ← 0x8C010004 and addr 4 ← 0xAC020008.
  - done pulses one cycle after the second write.
  - busy spans the load.
- Same load with byte_valid toggling 1/0 every cycle: identical writes; no byte lost or duplicated.
- start with word_count=0: done pulses one cycle after start; no mem_we; busy stays 0.
- start with word_count=257 (DEPTH_WORDS=256): err_overflow=1 and done pulses; no mem_we. A following valid start clears err_overflow.
- Assert rst_n=0 after 2 bytes of word 2 in an 8-word load:
  - All outputs return to reset values immediately.
  - Only the addr 0 write has occurred.
  - A new load then restarts at BASE_ADDR.
- Pulse start during COLLECT: ignored; the load completes with its original count.
